// File: rtl/life_ctrl.sv
// Sequencing controller for the 8x8 Game of Life evolve datapath: holds the generation
// register, commits grid_evolve on a tick, halts on extinction/still life/limit. Optional macro: LIFE_OSC2_DETECT_EN.
module life_ctrl #(
    parameter int TICK_DIV = 4,
    parameter int GEN_W    = 16,
    parameter int MAX_GEN  = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [63:0]      seed,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic [63:0]      grid_evolve,
    output logic [63:0]      grid,
    output logic [GEN_W-1:0] gen_count,
    output logic             running,
    output logic             done,
    output logic [2:0]       halt_cause
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]    TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [GEN_W:0]   MAX_GEN_EXT = (GEN_W + 1)'(MAX_GEN);
    localparam logic [GEN_W-1:0] GEN_ONES    = '1;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t          state_reg;
    logic [63:0]     grid_reg;
    logic [GEN_W-1:0] gen_count_reg;
    logic [TW-1:0]   tick_reg;
    logic            running_reg;
    logic            done_reg;
    logic [2:0]      halt_cause_reg;

    logic [GEN_W:0]   gen_plus;
    logic [GEN_W-1:0] gen_next;
    logic [2:0]       cause_next;
    logic             osc_hit;

`ifdef LIFE_OSC2_DETECT_EN
    logic [63:0] prev_reg;
    assign osc_hit = (gen_count_reg != '0) && (grid_evolve == prev_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_reg <= '0;
        end else if (load) begin
            prev_reg <= '0;
        end else if ((state_reg == IDLE && !stop && !start && step) ||
                     (state_reg == RUN && !stop && tick_reg == TICK_LAST)) begin
            // Same commit condition as the main sequencer below
            prev_reg <= grid_reg;
        end
    end
`else
    assign osc_hit = 1'b0;
`endif

    assign gen_plus = {1'b0, gen_count_reg} + (GEN_W + 1)'(1);
    assign gen_next = (gen_count_reg == GEN_ONES) ? gen_count_reg : gen_plus[GEN_W-1:0];

    // Halt checks in priority order; only meaningful on a commit edge.
    always_comb begin
        cause_next = 3'd0;
        if (grid_evolve == 64'd0)
            cause_next = 3'd1;
        else if (grid_evolve == grid_reg)
            cause_next = 3'd2;
        else if (osc_hit)
            cause_next = 3'd4;
        else if (MAX_GEN != 0 && gen_plus == MAX_GEN_EXT)
            cause_next = 3'd3;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            grid_reg       <= '0;
            gen_count_reg  <= '0;
            tick_reg       <= '0;
            running_reg    <= 1'b0;
            done_reg       <= 1'b0;
            halt_cause_reg <= 3'd0;
        end else if (load) begin
            state_reg      <= IDLE;
            grid_reg       <= seed;
            gen_count_reg  <= '0;
            tick_reg       <= '0;
            running_reg    <= 1'b0;
            done_reg       <= 1'b0;
            halt_cause_reg <= 3'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (stop) begin
                        // stop outranks start/step but has nothing to do here
                    end else if (start) begin
                        tick_reg <= '0;
                        if (grid_reg != 64'd0) begin
                            state_reg   <= RUN;
                            running_reg <= 1'b1;
                        end else begin
                            state_reg      <= HALT;
                            done_reg       <= 1'b1;
                            halt_cause_reg <= 3'd1;
                        end
                    end else if (step) begin
                        grid_reg      <= grid_evolve;
                        gen_count_reg <= gen_next;
                        if (cause_next != 3'd0) begin
                            state_reg      <= HALT;
                            done_reg       <= 1'b1;
                            halt_cause_reg <= cause_next;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_reg   <= IDLE;
                        running_reg <= 1'b0;
                        tick_reg    <= '0;
                    end else if (tick_reg == TICK_LAST) begin
                        tick_reg      <= '0;
                        grid_reg      <= grid_evolve;
                        gen_count_reg <= gen_next;
                        if (cause_next != 3'd0) begin
                            state_reg      <= HALT;
                            running_reg    <= 1'b0;
                            done_reg       <= 1'b1;
                            halt_cause_reg <= cause_next;
                        end
                    end else begin
                        tick_reg <= tick_reg + TW'(1);
                    end
                end
                default: begin
                    // HALT: only load or reset leaves
                end
            endcase
        end
    end

    assign grid       = grid_reg;
    assign gen_count  = gen_count_reg;
    assign running    = running_reg;
    assign done       = done_reg;
    assign halt_cause = halt_cause_reg;
endmodule
